// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              acc, pop;
  logic              load_main, load_skid, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  assign acc = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = FULL;
            load_main = 1'b1;
          end
        end
        FULL: begin
          if (acc && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end else if (acc) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end
        end
        SKID: begin
          if (pop) begin
            state_d        = FULL;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs depend on registered state only, so no input reaches an output combinationally.
  always_comb begin
    in_ready_o  = (state_q != SKID);
    out_valid_o = (state_q != EMPTY);
    out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  end

  assign out_data_o = main_data_q;

  // NOTE: the two entries are ordinary flops, so they are reset to give a known zero payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush_i) begin
      // Flush kills control only; data is left stale since it is never qualified without ctrl.
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main) begin
        main_ctrl_q <= in_ctrl_i;
        main_data_q <= in_data_i;
      end else if (main_from_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl_i;
        skid_data_q <= in_data_i;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (!out_valid_o && (bubble_cnt_o != '1))               bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus randomized traffic
// compared against a queue-based model of the stage contents.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i = '0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  item_t             q[$];
  logic [DATA_W-1:0] hold_data;
  int                m_stall, m_bubble;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_ctrl_i  (in_ctrl_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_ctrl_o (out_ctrl_o),
    .out_data_o (out_data_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    hold_data = '0;
    m_stall   = 0;
    m_bubble  = 0;
  endtask

  // The stage is a FIFO of depth two; flush empties it, acceptance needs a free slot.
  task automatic model_step();
    bit acc, pop;
    acc = in_valid_i && (q.size() < 2);
    pop = out_ready_i && (q.size() > 0);
    if (q.size() == 0)     m_bubble = (m_bubble < 15) ? m_bubble + 1 : 15;
    else if (!out_ready_i) m_stall  = (m_stall  < 15) ? m_stall  + 1 : 15;
    if (flush_i) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{c: in_ctrl_i, d: in_data_i});
    end
    if (q.size() > 0) hold_data = q[0].d;
  endtask

  task automatic compare_all();
    check("in_ready",  DATA_W'(in_ready_o),  DATA_W'(q.size() < 2));
    check("out_valid", DATA_W'(out_valid_o), DATA_W'(q.size() > 0));
    check("out_ctrl",  DATA_W'(out_ctrl_o),  (q.size() > 0) ? DATA_W'(q[0].c) : '0);
    check("out_data",  out_data_o,           (q.size() > 0) ? q[0].d : hold_data);
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt",  DATA_W'(stall_cnt_o),  DATA_W'(m_stall));
    check("bubble_cnt", DATA_W'(bubble_cnt_o), DATA_W'(m_bubble));
`endif
  endtask

  // Called just after a falling edge: drive, clock, then compare on the next falling edge.
  task automatic tick(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input bit r, input bit f);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    in_valid_i = 1'b0;
    do_reset();
    check("rst_valid", DATA_W'(out_valid_o), '0);
    check("rst_ready", DATA_W'(in_ready_o), DATA_W'(1));
    check("rst_data",  out_data_o, '0);

    for (int i = 0; i < 3; i++) tick(0, '0, '0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    check("bubble_after_3", DATA_W'(bubble_cnt_o), DATA_W'(3));
`endif

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 4; i++) begin
      tick(1, CTRL_W'(i + 1), DATA_W'(10 + i), 1, 0);
      check("stream_ctrl",  DATA_W'(out_ctrl_o), DATA_W'(i + 1));
      check("stream_valid", DATA_W'(out_valid_o), DATA_W'(1));
    end
    tick(0, '0, '0, 1, 0);
    check("stream_drain_ctrl", DATA_W'(out_ctrl_o), '0);

    // Fill the skid entry, then drain in order.
    tick(1, 16'h0011, DATA_W'(16'h1111), 0, 0);
    tick(1, 16'h0022, DATA_W'(16'h2222), 0, 0);
    check("skid_ready", DATA_W'(in_ready_o), '0);
    tick(0, '0, '0, 1, 0);
    check("skid_pop1_ctrl",  DATA_W'(out_ctrl_o), DATA_W'(16'h0022));
    check("skid_pop1_ready", DATA_W'(in_ready_o), DATA_W'(1));
    tick(0, '0, '0, 1, 0);
    check("skid_drained", DATA_W'(out_valid_o), '0);

    // Flush while in SKID with an offered item.
    tick(1, 16'h0033, DATA_W'(3), 0, 0);
    tick(1, 16'h0044, DATA_W'(4), 0, 0);
    tick(1, 16'h00FF, DATA_W'(5), 0, 1);
    check("flush_valid", DATA_W'(out_valid_o), '0);
    check("flush_ctrl",  DATA_W'(out_ctrl_o), '0);
    check("flush_ready", DATA_W'(in_ready_o), DATA_W'(1));
    tick(0, '0, '0, 1, 0);
    check("flush_no_ff", DATA_W'(out_ctrl_o), '0);

    // Flush coinciding with acceptance from EMPTY.
    tick(1, 16'h8000, DATA_W'(6), 1, 1);
    check("flush_acc_valid", DATA_W'(out_valid_o), '0);
    check("flush_acc_ctrl",  DATA_W'(out_ctrl_o), '0);

    // Hold FULL with no downstream ready; stall counter saturates.
    tick(1, 16'h0055, DATA_W'(7), 0, 0);
    for (int i = 0; i < 20; i++) tick(0, '0, '0, 0, 0);
    check("stall_hold_ctrl", DATA_W'(out_ctrl_o), DATA_W'(16'h0055));
`ifdef PIPE_PERF_CNT_EN
    check("stall_sat", DATA_W'(stall_cnt_o), DATA_W'(15));
`endif

    // Asynchronous reset mid-cycle while FULL.
    tick(1, 16'hFFFF, rand_data(), 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", DATA_W'(out_valid_o), '0);
    check("async_ctrl",  DATA_W'(out_ctrl_o), '0);
    check("async_ready", DATA_W'(in_ready_o), DATA_W'(1));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) != 0), CTRL_W'($urandom), rand_data(),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed decode/execute pipeline register: one generic inter-stage register with a valid/ready handshake, a 2-entry skid buffer, flush-to-bubble, and a control payload forced to zero on bubbles.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W).
- Control (RegWrite, MemWrite, Jump, Branch...) and data (RD1, RD2, PC, Imm...) travel as two packed buses.
- A flushed or empty stage never presents non-zero control downstream.

Parameters:
- CTRL_W, 16, width of the control payload; must be zeroed on bubbles.
- DATA_W, 128, width of the data payload; holds its last value on bubbles.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; empties the stage at the next edge
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept; registered, equals (state != SKID)
- in_ctrl_i  in  CTRL_W  upstream control payload
- in_data_i  in  DATA_W  upstream data payload
- out_valid_o  out  1  downstream payload valid
- out_ready_i  in  1  downstream accepts
- out_ctrl_o  out  CTRL_W  control payload; all zeros whenever out_valid_o=0
- out_data_o  out  DATA_W  data payload from the main entry
- stall_cnt_o  out  CNT_W  present only with PIPE_PERF_CNT_EN
- bubble_cnt_o  out  CNT_W  present only with PIPE_PERF_CNT_EN

Behaviour:
- Reset is asynchronous, active-low: clk is the only clock, rst_n is asynchronous active-low.
- Reset values:
  - state=EMPTY; out_valid_o=0; in_ready_o=1.
  - main and skid entries (ctrl and data) = 0, so out_ctrl_o=0 and out_data_o=0.
  - Counters = 0.
- Handshake events:
  - acc = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - Payloads are sampled on acc only.
- Latency:
  - 1 cycle from acc to out_valid_o when the stage is EMPTY, or FULL with pop.
  - Full throughput of 1 item/cycle while out_ready_i=1.
- State machine (evaluated only when flush_i=0):
  - EMPTY: acc -> FULL, main<=in. Otherwise stay.
  - FULL:
    - acc & pop -> FULL, main<=in.
    - pop & !acc -> EMPTY.
    - acc & !pop -> SKID, skid<=in, main held.
    - Otherwise hold.
  - SKID: in_ready_o=0, so no acc is possible. pop -> FULL, main<=skid. Otherwise hold.
- Outputs:
  - out_valid_o = (state != EMPTY).
  - out_ctrl_o = out_valid_o ? main.ctrl : 0.
  - out_data_o = main.data, registered, no bypass from inputs.
- Flush:
  - flush_i=1 at an edge -> state=EMPTY regardless of state, acc or pop.
  - Main and skid ctrl are cleared to 0; data entries are left unchanged.
  - An item accepted in the same cycle as flush is discarded. Upstream treats it as handshaken.
  - A pop in the flush cycle is still a valid transfer downstream.
  - in_ready_o=1 in the cycle after flush.
- Stability: while out_valid_o=1 and out_ready_i=0, out_ctrl_o and out_data_o are held bit-stable until pop or flush.
- Ordering: FIFO order is preserved; the skid entry is always younger than main.
- Reset mid-operation: any buffered items are lost immediately (asynchronous). No output glitches to a non-zero out_ctrl_o after rst_n deasserts.
- No combinational path from in_valid_i or out_ready_i to any output.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every cycle with out_valid_o=1 & out_ready_i=0.
  - bubble_cnt_o increments on every cycle with out_valid_o=0.
  - Both saturate at 2^CNT_W-1.
  - Both clear only on rst_n, not on flush.
- Not defined: both ports and their counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then stream 4 items (ctrl=0x0001..0x0004, data=0xA..0xD) with out_ready_i=1 -> each appears 1 cycle after acceptance, back-to-back, out_valid_o continuously 1 for 4 cycles, then EMPTY with out_ctrl_o=0.
- out_ready_i=0; push ctrl=0x0011 then 0x0022 -> in_ready_o drops to 0 after the second acc (SKID). Raise out_ready_i -> 0x0011 then 0x0022 delivered in order, in_ready_o=1 the cycle after the first pop.
- In SKID state assert flush_i one cycle with in_valid_i=1, ctrl=0x00FF -> next cycle out_valid_o=0, out_ctrl_o=0x0000, in_ready_o=1, 0x00FF never emitted.
- Flush in the same cycle as acc from EMPTY (ctrl=0x8000) -> out_valid_o stays 0, out_ctrl_o stays 0.
- Drop rst_n asynchronously mid-cycle while FULL with ctrl=0xFFFF -> out_valid_o=0 and out_ctrl_o=0 immediately, before the next clk edge.
- With PIPE_PERF_CNT_EN and CNT_W=4: hold the stage FULL with out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15. After reset, 3 idle cycles -> bubble_cnt_o=3.
